// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sharing one fixed-latency memory port.
// Latency: grant 1 cycle after the IDLE sample; ack MEM_LATENCY+1 cycles after it; MEM_LATENCY+2 cycles per access.
// Backpressure: one transaction at a time; the losing master holds req and wins the next IDLE sample.
module mem_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wr_data,
    input  logic [2:0]  i_m0_rd_mask,
    input  logic [1:0]  i_m0_wr_mask,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wr_data,
    input  logic [2:0]  i_m1_rd_mask,
    input  logic [1:0]  i_m1_wr_mask,
    output logic        o_m0_gnt,
    output logic        o_m0_ack,
    output logic [31:0] o_m0_rd_data,
    output logic        o_m1_gnt,
    output logic        o_m1_ack,
    output logic [31:0] o_m1_rd_data,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wr_data,
    output logic [2:0]  o_mem_rd_mask,
    output logic [1:0]  o_mem_wr_mask,
    input  logic [31:0] i_mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The ACCESS window lasts CNT_LOAD+1 cycles; the last one is at count 0.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t     state;
    logic       r_last;     // master granted most recently
    logic       winner;     // master owning the current transaction
    logic [3:0] cnt;
    logic       any_req;
    logic       pick;

    // Winner selection: a lone requester wins; on a tie the master that was not granted last wins.
    always_comb begin
        any_req = i_m0_req | i_m1_req;
        if (i_m0_req && i_m1_req) begin
            pick = ~r_last;
        end else begin
            pick = i_m1_req;
        end
    end

    // Transaction FSM; the memory lines double as the latch for the winner's request fields.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            r_last        <= 1'b1;
            winner        <= 1'b0;
            cnt           <= 4'd0;
            o_m0_gnt      <= 1'b0;
            o_m0_ack      <= 1'b0;
            o_m0_rd_data  <= 32'd0;
            o_m1_gnt      <= 1'b0;
            o_m1_ack      <= 1'b0;
            o_m1_rd_data  <= 32'd0;
            o_mem_addr    <= 32'd0;
            o_mem_wr_data <= 32'd0;
            o_mem_rd_mask <= 3'd0;
            o_mem_wr_mask <= 2'd0;
        end else begin
            o_m0_gnt <= 1'b0;
            o_m0_ack <= 1'b0;
            o_m1_gnt <= 1'b0;
            o_m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner <= pick;
                        r_last <= pick;
                        cnt    <= CNT_LOAD;
                        state  <= ACCESS;
                        if (pick) begin
                            o_mem_addr    <= i_m1_addr;
                            o_mem_wr_data <= i_m1_wr_data;
                            o_mem_rd_mask <= i_m1_rd_mask;
                            o_mem_wr_mask <= i_m1_wr_mask;
                            o_m1_gnt      <= 1'b1;
                        end else begin
                            o_mem_addr    <= i_m0_addr;
                            o_mem_wr_data <= i_m0_wr_data;
                            o_mem_rd_mask <= i_m0_rd_mask;
                            o_mem_wr_mask <= i_m0_wr_mask;
                            o_m0_gnt      <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Masks drop to 0 for RESP; addr/wr_data keep their last value.
                        state         <= RESP;
                        o_mem_rd_mask <= 3'd0;
                        o_mem_wr_mask <= 2'd0;
                        if (winner) begin
                            o_m1_ack <= 1'b1;
                            if (o_mem_rd_mask != 3'd0) begin
                                o_m1_rd_data <= i_mem_rd_data;
                            end
                        end else begin
                            o_m0_ack <= 1'b1;
                            if (o_mem_rd_mask != 3'd0) begin
                                o_m0_rd_data <= i_mem_rd_data;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 and latency 3) with a small memory model.
// Stimulus pushes expected grants/acks into queues; a negedge monitor pops and compares them.
// The memory returns valid data only in the last ACCESS cycle, so early or late capture is visible.
module tb_mem_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        int          d;
        int          m;
        logic [31:0] rd;
    } ack_exp_t;

    logic        clk = 1'b0;
    logic        rst_n    [2];
    logic        req      [2][2];
    logic [31:0] addr     [2][2];
    logic [31:0] wd       [2][2];
    logic [2:0]  rm       [2][2];
    logic [1:0]  wm       [2][2];
    logic        gnt      [2][2];
    logic        ack      [2][2];
    logic [31:0] rdd      [2][2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wd   [2];
    logic [2:0]  mem_rm   [2];
    logic [1:0]  mem_wm   [2];
    logic [31:0] mem_rd   [2];
    int          seen     [2];
    logic [31:0] model_rd [2][2];
    int          gnt_cyc  [2];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          gnt_seen = 0;
    int          gnt_q [$];
    ack_exp_t    ack_q [$];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(LAT0)) u_l1 (
        .i_clk(clk), .i_reset_n(rst_n[0]),
        .i_m0_req(req[0][0]), .i_m0_addr(addr[0][0]), .i_m0_wr_data(wd[0][0]),
        .i_m0_rd_mask(rm[0][0]), .i_m0_wr_mask(wm[0][0]),
        .i_m1_req(req[0][1]), .i_m1_addr(addr[0][1]), .i_m1_wr_data(wd[0][1]),
        .i_m1_rd_mask(rm[0][1]), .i_m1_wr_mask(wm[0][1]),
        .o_m0_gnt(gnt[0][0]), .o_m0_ack(ack[0][0]), .o_m0_rd_data(rdd[0][0]),
        .o_m1_gnt(gnt[0][1]), .o_m1_ack(ack[0][1]), .o_m1_rd_data(rdd[0][1]),
        .o_mem_addr(mem_addr[0]), .o_mem_wr_data(mem_wd[0]),
        .o_mem_rd_mask(mem_rm[0]), .o_mem_wr_mask(mem_wm[0]),
        .i_mem_rd_data(mem_rd[0])
    );

    mem_arbiter #(.MEM_LATENCY(LAT1)) u_l3 (
        .i_clk(clk), .i_reset_n(rst_n[1]),
        .i_m0_req(req[1][0]), .i_m0_addr(addr[1][0]), .i_m0_wr_data(wd[1][0]),
        .i_m0_rd_mask(rm[1][0]), .i_m0_wr_mask(wm[1][0]),
        .i_m1_req(req[1][1]), .i_m1_addr(addr[1][1]), .i_m1_wr_data(wd[1][1]),
        .i_m1_rd_mask(rm[1][1]), .i_m1_wr_mask(wm[1][1]),
        .o_m0_gnt(gnt[1][0]), .o_m0_ack(ack[1][0]), .o_m0_rd_data(rdd[1][0]),
        .o_m1_gnt(gnt[1][1]), .o_m1_ack(ack[1][1]), .o_m1_rd_data(rdd[1][1]),
        .o_mem_addr(mem_addr[1]), .o_mem_wr_data(mem_wd[1]),
        .o_mem_rd_mask(mem_rm[1]), .o_mem_wr_mask(mem_wm[1]),
        .i_mem_rd_data(mem_rd[1])
    );

    // Memory contents: f(0x100) = 0xDEADBEEF.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // Read data is only valid in the final ACCESS cycle of a read.
    assign mem_rd[0] = (seen[0] == LAT0 - 1) ? memf(mem_addr[0]) : 32'hBAD0BAD0;
    assign mem_rd[1] = (seen[1] == LAT1 - 1) ? memf(mem_addr[1]) : 32'hBAD0BAD0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            seen[d] <= (mem_rm[d] != 3'd0) ? seen[d] + 1 : 0;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic flag(input string n, input string act, input string exp);
        total++;
        bad++;
        $display("FAIL %s: got %s want %s (t=%0t)", n, act, exp, $time);
    endtask

    // Scoreboard monitor: every grant and ack pulse must match the head of its queue.
    always @(negedge clk) begin
        ack_exp_t a;
        int       e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                if (gnt[d][m] === 1'b1) begin
                    gnt_seen++;
                    gnt_cyc[d] = cyc;
                    if (gnt_q.size() == 0) begin
                        flag("gnt_unexpected", $sformatf("gnt dut%0d m%0d", d, m), "no grant");
                    end else begin
                        e = gnt_q.pop_front();
                        chk("gnt_who", 32'(d * 2 + m), 32'(e));
                    end
                end
                if (ack[d][m] === 1'b1) begin
                    if (ack_q.size() == 0) begin
                        flag("ack_unexpected", $sformatf("ack dut%0d m%0d", d, m), "no ack");
                    end else begin
                        a = ack_q.pop_front();
                        chk("ack_who", 32'(d * 2 + m), 32'(a.d * 2 + a.m));
                        chk("ack_rd_data", rdd[d][m], a.rd);
                        chk("ack_latency", 32'(cyc - gnt_cyc[d]), 32'(lat_of(d)));
                    end
                end
            end
        end
    end

    task automatic chk_zero(input int d);
        chk("rst_m0_gnt", 32'(gnt[d][0]), 32'd0);
        chk("rst_m1_gnt", 32'(gnt[d][1]), 32'd0);
        chk("rst_m0_ack", 32'(ack[d][0]), 32'd0);
        chk("rst_m1_ack", 32'(ack[d][1]), 32'd0);
        chk("rst_m0_rd_data", rdd[d][0], 32'd0);
        chk("rst_m1_rd_data", rdd[d][1], 32'd0);
        chk("rst_mem_addr", mem_addr[d], 32'd0);
        chk("rst_mem_wr_data", mem_wd[d], 32'd0);
        chk("rst_mem_rd_mask", 32'(mem_rm[d]), 32'd0);
        chk("rst_mem_wr_mask", 32'(mem_wm[d]), 32'd0);
    endtask

    // Drive req until granted, then scramble the fields; memory lines must keep the latched values.
    task automatic issue(input int d, input int m, input logic [31:0] a, input logic [31:0] w,
                         input logic [2:0] r, input logic [1:0] wmk);
        logic [31:0] exp_rd;
        bit          got;
        exp_rd = (r != 3'd0) ? memf(a) : model_rd[d][m];
        model_rd[d][m] = exp_rd;
        gnt_q.push_back(d * 2 + m);
        ack_q.push_back('{d, m, exp_rd});
        @(negedge clk);
        req[d][m] = 1'b1; addr[d][m] = a; wd[d][m] = w; rm[d][m] = r; wm[d][m] = wmk;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (gnt[d][m] === 1'b1) got = 1'b1;
        end
        req[d][m] = 1'b0; addr[d][m] = a ^ 32'h300; wd[d][m] = ~w; rm[d][m] = 3'd0; wm[d][m] = 2'd0;
        if (!got) begin
            flag("gnt_timeout", "no grant in 40 cycles", "grant");
            return;
        end
        for (int c = 1; c <= lat_of(d); c++) begin
            if (c > 1) @(negedge clk);
            chk("acc_addr", mem_addr[d], a);
            chk("acc_wr_data", mem_wd[d], w);
            chk("acc_rd_mask", 32'(mem_rm[d]), 32'(r));
            chk("acc_wr_mask", 32'(mem_wm[d]), 32'(wmk));
        end
        @(negedge clk);
        chk("resp_rd_mask", 32'(mem_rm[d]), 32'd0);
        chk("resp_wr_mask", 32'(mem_wm[d]), 32'd0);
        chk("resp_addr_hold", mem_addr[d], a);
    endtask

    // Both masters hold req; grants must alternate starting with 'first'.
    task automatic sim_both(input int d, input int first);
        int          g0;
        int          cur;
        logic [31:0] e;
        cur = first;
        for (int i = 0; i < 4; i++) begin
            e = memf((cur == 1) ? 32'h20 : 32'h10);
            model_rd[d][cur] = e;
            gnt_q.push_back(d * 2 + cur);
            ack_q.push_back('{d, cur, e});
            cur = 1 - cur;
        end
        @(negedge clk);
        req[d][0] = 1'b1; addr[d][0] = 32'h10; wd[d][0] = 32'h0; rm[d][0] = 3'b001; wm[d][0] = 2'b00;
        req[d][1] = 1'b1; addr[d][1] = 32'h20; wd[d][1] = 32'h0; rm[d][1] = 3'b010; wm[d][1] = 2'b00;
        g0 = gnt_seen;
        for (int k = 0; k < 200 && gnt_seen < g0 + 4; k++) @(negedge clk);
        req[d][0] = 1'b0;
        req[d][1] = 1'b0;
        if (gnt_seen < g0 + 4) flag("sim_timeout", $sformatf("%0d grants", gnt_seen - g0), "4 grants");
        repeat (lat_of(d) + 3) @(negedge clk);
    endtask

    initial begin
        bit got;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; addr[d][m] = 32'd0; wd[d][m] = 32'd0;
                rm[d][m] = 3'd0; wm[d][m] = 2'd0; model_rd[d][m] = 32'd0;
            end
            gnt_cyc[d] = 0;
        end
        #3;
        chk_zero(0);
        chk_zero(1);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Latency 1: read, write, no-op, combined read+write.
        issue(0, 0, 32'h100, 32'h0, 3'b111, 2'b00);
        chk("l1_read_value", rdd[0][0], 32'hDEADBEEF);
        issue(0, 0, 32'h104, 32'hAAAA5555, 3'b000, 2'b01);
        issue(0, 1, 32'h108, 32'h11111111, 3'b000, 2'b00);
        issue(0, 1, 32'h44, 32'h22222222, 3'b100, 2'b10);
        chk("both_mask_value", rdd[0][1], 32'hDEADBFAB);

        // Latency 3: write, then read whose fields change right after the grant.
        issue(1, 1, 32'h40, 32'h12345678, 3'b000, 2'b11);
        chk("l3_write_rd_unchanged", rdd[1][1], 32'h0);
        issue(1, 0, 32'h100, 32'h0, 3'b111, 2'b00);

        // Reset in cycle 2 of a latency-3 read: transaction dropped, no ack.
        gnt_q.push_back(2);
        @(negedge clk);
        req[1][0] = 1'b1; addr[1][0] = 32'h60; rm[1][0] = 3'b011; wm[1][0] = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (gnt[1][0] === 1'b1) got = 1'b1;
        end
        req[1][0] = 1'b0;
        if (!got) flag("midop_gnt_timeout", "no grant", "grant");
        @(negedge clk);
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk_zero(1);
        model_rd[1][0] = 32'd0;
        model_rd[1][1] = 32'd0;
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (6) @(negedge clk);
        chk("midop_no_pending_ack", 32'(ack_q.size()), 32'd0);

        issue(1, 1, 32'h80, 32'h0, 3'b100, 2'b00);
        sim_both(1, 0);

        repeat (4) @(negedge clk);
        chk("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
